// File: rtl/updown_count_pkg.sv
// Shared definitions for the UpDownCount counter and its monitor:
// state encoding, count-pair type and the next-pair prediction rule.
package updown_count_pkg;

   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] COUNT_MAX = '1;

   // Pairs are carried at a fixed maximum width; callers mask to their own WIDTH.
   localparam int PAIR_MAXW = 32;

   typedef enum logic {ACQ, TRACK} mon_state_t;

   typedef struct packed {
      logic [PAIR_MAXW-1:0] up;
      logic [PAIR_MAXW-1:0] dn;
   } count_pair_t;

   // Expected pair one edge after (p, e, s) was sampled. Swap beats enable.
   function automatic count_pair_t predict_next(input count_pair_t p,
                                                input logic e,
                                                input logic s,
                                                input logic [PAIR_MAXW-1:0] mask);
      count_pair_t n;
      n = p;
      if (s) begin
         n.up = p.dn;
         n.dn = p.up;
      end else if (e) begin
         n.up = (p.up + 32'd1) & mask;
         n.dn = (p.dn - 32'd1) & mask;
      end
      return n;
   endfunction

endpackage

// File: rtl/updown_count_monitor_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);

   // Count up to all-ones and hold there until cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 q <= '0;
      else if (clr)            q <= '0;
      else if (inc && q != '1) q <= q + 1'b1;
   end

endmodule

// File: rtl/updown_count_monitor.sv
// Passive checker for UpDownCount: predicts each next count pair from the
// previous edge's sample and flags deviations, wraps and error history.
module updown_count_monitor
   import updown_count_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int ERRW  = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Enable,
   input  logic             Swap,
   input  logic [WIDTH-1:0] UpCountS,
   input  logic [WIDTH-1:0] DownCountS,
   input  logic             ClearErr,
   output logic             Locked,
   output logic             Mismatch,
   output logic             Sticky,
   output logic [ERRW-1:0]  ErrorCount,
   output logic             WrapUp,
   output logic             WrapDown
);

   localparam logic [PAIR_MAXW-1:0] MASK = PAIR_MAXW'({WIDTH{1'b1}});

   mon_state_t       state, state_nxt;
   logic [WIDTH-1:0] up_q, dn_q;
   logic             en_q, sw_q;
   count_pair_t      prev_p, pred_p;
   logic             mis_c, step_c, wup_c, wdn_c;

   // Next state and comparison of the live pair against the prediction.
   always_comb begin
      state_nxt = TRACK;
      mis_c     = 1'b0;
      step_c    = 1'b0;
      wup_c     = 1'b0;
      wdn_c     = 1'b0;
      prev_p.up = PAIR_MAXW'(up_q);
      prev_p.dn = PAIR_MAXW'(dn_q);
      pred_p    = predict_next(prev_p, en_q, sw_q, MASK);
      case (state)
         ACQ:   state_nxt = TRACK;
         TRACK: begin
            mis_c  = (pred_p.up != PAIR_MAXW'(UpCountS)) ||
                     (pred_p.dn != PAIR_MAXW'(DownCountS));
            step_c = en_q & ~sw_q;
            wup_c  = ~mis_c & step_c & (up_q == '1);
            wdn_c  = ~mis_c & step_c & (dn_q == '0);
         end
         default: state_nxt = ACQ;
      endcase
   end

   // State register; leaving ACQ after one capture edge.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state <= ACQ;
      else       state <= state_nxt;
   end

   // Sample every edge; the observed pair is always the next base, which
   // resynchronises after a fault so one fault gives one error.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         up_q <= '0;
         dn_q <= '0;
         en_q <= 1'b0;
         sw_q <= 1'b0;
      end else begin
         up_q <= UpCountS;
         dn_q <= DownCountS;
         en_q <= Enable;
         sw_q <= Swap;
      end
   end

   // Registered single-cycle event pulses.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         Mismatch <= 1'b0;
         WrapUp   <= 1'b0;
         WrapDown <= 1'b0;
      end else begin
         Mismatch <= mis_c;
         WrapUp   <= wup_c;
         WrapDown <= wdn_c;
      end
   end

   // Sticky error flag; a coincident clear wins over a new mismatch.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)         Sticky <= 1'b0;
      else if (ClearErr) Sticky <= 1'b0;
      else if (mis_c)    Sticky <= 1'b1;
   end

   assign Locked = (state == TRACK);

   sat_counter #(.W(ERRW)) u_errcnt (
      .clk (Clock),
      .rst (Reset),
      .inc (mis_c),
      .clr (ClearErr),
      .q   (ErrorCount)
   );

endmodule

// File: tb/tb_updown_count_monitor.sv
// Randomised and directed bench for updown_count_monitor against a
// behavioural model of the counter contract.
module tb_updown_count_monitor;

   localparam int W      = 4;
   localparam int EW     = 8;
   localparam int MAXV   = (1 << W) - 1;
   localparam int ERRMAX = (1 << EW) - 1;

   logic          Clock = 1'b0;
   logic          Reset = 1'b1;
   logic          Enable = 1'b0, Swap = 1'b0, ClearErr = 1'b0;
   logic [W-1:0]  UpCountS = '0, DownCountS = '0;
   logic          Locked, Mismatch, Sticky, WrapUp, WrapDown;
   logic [EW-1:0] ErrorCount;

   updown_count_monitor #(.WIDTH(W), .ERRW(EW)) dut (
      .Clock(Clock), .Reset(Reset), .Enable(Enable), .Swap(Swap),
      .UpCountS(UpCountS), .DownCountS(DownCountS), .ClearErr(ClearErr),
      .Locked(Locked), .Mismatch(Mismatch), .Sticky(Sticky),
      .ErrorCount(ErrorCount), .WrapUp(WrapUp), .WrapDown(WrapDown)
   );

   always #5 Clock = ~Clock;

   int pass_n = 0, tot_n = 0;
   int mis_seen = 0, wu_seen = 0, wd_seen = 0;
   int cu, cd;

   // reference model state: last observed sample plus expected outputs
   bit m_have, m_e, m_s;
   int m_u, m_d, m_err;
   bit m_sticky, m_locked, m_mis, m_wu, m_wd;

   task automatic chk(input string tag, input int obs, input int exp);
      tot_n++;
      if (obs == exp) pass_n++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
   endtask

   task automatic chk_all();
      chk("locked",   int'(Locked),     int'(m_locked));
      chk("mismatch", int'(Mismatch),   int'(m_mis));
      chk("sticky",   int'(Sticky),     int'(m_sticky));
      chk("errcnt",   int'(ErrorCount), m_err);
      chk("wrapup",   int'(WrapUp),     int'(m_wu));
      chk("wrapdown", int'(WrapDown),   int'(m_wd));
   endtask

   // counter contract: what a healthy counter shows one edge later
   task automatic advance(input bit e, input bit s, input int u, input int d,
                          output int nu, output int nd);
      if (s) begin
         nu = d; nd = u;
      end else begin
         nu = (u + int'(e)) % (MAXV + 1);
         nd = (d + MAXV + 1 - int'(e)) % (MAXV + 1);
      end
   endtask

   task automatic model_reset();
      m_have = 0; m_err = 0; m_sticky = 0; m_locked = 0;
      m_mis = 0; m_wu = 0; m_wd = 0;
   endtask

   task automatic model_edge(input bit e, input bit s, input int u, input int d, input bit clr);
      int pu, pd;
      m_mis = 0; m_wu = 0; m_wd = 0;
      if (m_have) begin
         advance(m_e, m_s, m_u, m_d, pu, pd);
         m_mis = !(pu == u && pd == d);
         if (!m_mis && !m_s && m_e) begin
            m_wu = (m_u == MAXV);
            m_wd = (m_d == 0);
         end
      end
      if (clr) begin
         m_err = 0; m_sticky = 0;
      end else if (m_mis) begin
         if (m_err < ERRMAX) m_err++;
         m_sticky = 1;
      end
      m_locked = 1;
      m_have = 1; m_e = e; m_s = s; m_u = u; m_d = d;
   endtask

   // one clock: drive at negedge (with a mid-cycle Enable glitch), check after posedge
   task automatic step(input bit e, input bit s, input int u, input int d, input bit clr);
      @(negedge Clock);
      Enable = e; Swap = s; ClearErr = clr;
      UpCountS = W'(u); DownCountS = W'(d);
      model_edge(e, s, u, d, clr);
      #1 Enable = ~e;
      #1 Enable = e;
      @(posedge Clock);
      #1;
      chk_all();
      if (Mismatch) mis_seen++;
      if (WrapUp)   wu_seen++;
      if (WrapDown) wd_seen++;
      advance(e, s, u, d, cu, cd);
   endtask

   task automatic cnt(input bit e, input bit s);
      step(e, s, cu, cd, 1'b0);
   endtask

   initial begin
      // reset state
      model_reset();
      #7;
      chk_all();
      Reset = 1'b0;

      // clean counting from U=0, D=15 through both wraps
      cu = 0; cd = MAXV;
      mis_seen = 0; wu_seen = 0; wd_seen = 0;
      for (int i = 0; i < 20; i++) cnt(1'b1, 1'b0);
      chk("count_mis_total", mis_seen, 0);
      chk("count_wrapup_total", wu_seen, 1);
      chk("count_wrapdn_total", wd_seen, 1);

      // swap at U=5, D=10, then resume counting
      while (cu != 5) cnt(1'b1, 1'b0);
      chk("swap_setup_d", cd, 10);
      mis_seen = 0; wu_seen = 0; wd_seen = 0;
      cnt(1'b1, 1'b1);
      cnt(1'b1, 1'b0);
      chk("swap_u", int'(UpCountS), 10);
      cnt(1'b1, 1'b0);
      chk("resume_u", int'(UpCountS), 11);
      chk("resume_d", int'(DownCountS), 4);
      chk("swap_mis_total", mis_seen + wu_seen + wd_seen, 0);

      // single fault: 7 where 6 expected, then a correct step to 8
      while (cu != 6) cnt(1'b1, 1'b0);
      mis_seen = 0;
      step(1'b1, 1'b0, 7, cd, 1'b0);
      chk("fault_mis", int'(Mismatch), 1);
      chk("fault_sticky", int'(Sticky), 1);
      cnt(1'b1, 1'b0);
      chk("fault_next_u", int'(UpCountS), 8);
      chk("fault_mis_total", mis_seen, 1);

      // 300 consecutive faults saturate the counter
      for (int i = 0; i < 300; i++) step(1'b0, 1'b0, (i % 2) + 1, 0, 1'b0);
      chk("sat_errcnt", int'(ErrorCount), ERRMAX);
      step(1'b0, 1'b0, 5, 0, 1'b1);
      chk("clr_errcnt", int'(ErrorCount), 0);
      chk("clr_sticky", int'(Sticky), 0);
      chk("clr_mis", int'(Mismatch), 1);

      // one more fault, count to U=9, then a short asynchronous reset
      step(1'b0, 1'b0, (cu + 3) % (MAXV + 1), cd, 1'b0);
      while (cu != 9) cnt(1'b1, 1'b0);
      cnt(1'b1, 1'b0);
      Reset = 1'b1;
      model_reset();
      #1 chk_all();
      #2 Reset = 1'b0;
      cu = $urandom_range(0, MAXV);
      cd = $urandom_range(0, MAXV);
      mis_seen = 0;
      cnt(1'b1, 1'b0);
      chk("post_rst_locked", int'(Locked), 1);
      for (int i = 0; i < 4; i++) cnt(1'b1, 1'b0);
      chk("post_rst_mis_total", mis_seen, 0);

      // idle hold, then a counter that steps on its own
      mis_seen = 0; wu_seen = 0; wd_seen = 0;
      for (int i = 0; i < 10; i++) cnt(1'b0, 1'b0);
      step(1'b0, 1'b0, (cu + 1) % (MAXV + 1), cd, 1'b0);
      for (int i = 0; i < 3; i++) cnt(1'b0, 1'b0);
      chk("idle_mis_total", mis_seen, 1);
      chk("idle_wrap_total", wu_seen + wd_seen, 0);

      // randomised traffic with occasional faults and clears
      for (int i = 0; i < 400; i++) begin
         bit e, s, clr;
         e   = ($urandom_range(0, 3) != 0);
         s   = ($urandom_range(0, 7) == 0);
         clr = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 9) == 0)
            step(e, s, $urandom_range(0, MAXV), $urandom_range(0, MAXV), clr);
         else
            step(e, s, cu, cd, clr);
      end

      $display("%0d/%0d checks passed", pass_n, tot_n);
      $finish;
   end

endmodule
